// File: rtl/mctp_axi_wr_rx.sv
// AXI4 write slave for MCTP-over-PCIe-VDM bursts: checks the beat-0 TLP header and the MCTP assembly sequence, forwards beats, returns BRESP.
// Latency: W handshake in T -> payload valid in T+1; final W handshake in T -> BVALID in T+1.
// Backpressure: WREADY follows the one-entry payload register (empty or I_PLD_READY); rejected packets are drained without stalling.
// Optional feature: define MCTP_SEQ_CHECK_EN to enable the type/seq/tag assembly checks.
module mctp_axi_wr_rx (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic [6:0]   I_AWID,
  input  logic [63:0]  I_AWADDR,
  input  logic [7:0]   I_AWLEN,
  input  logic [2:0]   I_AWSIZE,
  input  logic [1:0]   I_AWBURST,
  input  logic         I_AWVALID,
  output logic         O_AWREADY,
  input  logic [255:0] I_WDATA,
  input  logic         I_WLAST,
  input  logic         I_WVALID,
  output logic         O_WREADY,
  output logic [6:0]   O_BID,
  output logic [1:0]   O_BRESP,
  output logic         O_BVALID,
  input  logic         I_BREADY,
  output logic [255:0] O_PLD_DATA,
  output logic         O_PLD_VALID,
  input  logic         I_PLD_READY,
  output logic         O_PLD_SOM,
  output logic         O_PLD_EOM,
  output logic         O_PLD_LAST,
  output logic [3:0]   O_PLD_TAG,
  output logic [1:0]   O_PLD_SEQ,
  output logic         O_ABORT
);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_RESP} state_t;

  localparam logic [1:0] TY_M  = 2'b00;
  localparam logic [1:0] TY_L  = 2'b01;
  localparam logic [1:0] TY_S  = 2'b10;
  localparam logic [1:0] TY_SG = 2'b11;

  state_t      state, state_nxt;
  logic        rst_done;
  logic [6:0]  aw_id;
  logic [7:0]  aw_len;
  logic [7:0]  beat_cnt;
  logic        pkt_drop;
  logic        pkt_eom;
  logic        wlast_err;
  logic [1:0]  bresp_q;

  logic        asm_active;
  logic [1:0]  exp_seq;
  logic [3:0]  cur_tag;

  // Address attributes that this slave deliberately ignores
  logic        unused_aw;
  assign unused_aw = ^{I_AWADDR, I_AWSIZE, I_AWBURST};

  logic aw_hs, w_hs, b_hs;
  logic first_beat, last_beat;
  assign aw_hs      = I_AWVALID && O_AWREADY;
  assign w_hs       = I_WVALID && O_WREADY;
  assign b_hs       = O_BVALID && I_BREADY;
  assign first_beat = (beat_cnt == 8'd0);
  assign last_beat  = (beat_cnt == aw_len);

  // Header fields, meaningful only on beat 0
  logic [1:0] hdr_type;
  logic [1:0] hdr_seq;
  logic [3:0] hdr_tag;
  logic       fmt_ok;
  assign hdr_type = I_WDATA[127:126];
  assign hdr_seq  = I_WDATA[125:124];
  assign hdr_tag  = I_WDATA[123:120];
  assign fmt_ok   = (I_WDATA[7:3] == 5'b01110) && (I_WDATA[63:56] == 8'h7F) &&
                    (I_WDATA[95:80] == 16'hB41A);

`ifdef MCTP_SEQ_CHECK_EN
  logic seq_ok;
  assign seq_ok = asm_active && (hdr_tag == cur_tag) && (hdr_seq == exp_seq);
`endif

  logic       hdr_ok;
  logic       abort_nxt;
  logic       asm_nxt;
  logic [1:0] exp_nxt;
  logic [3:0] tag_nxt;

  // Header verdict and assembly-state update for the packet presented on beat 0
  always_comb begin
    hdr_ok    = 1'b0;
    abort_nxt = 1'b0;
    asm_nxt   = asm_active;
    exp_nxt   = exp_seq;
    tag_nxt   = cur_tag;
    if (fmt_ok) begin
      case (hdr_type)
        TY_S: begin
          hdr_ok    = 1'b1;
          abort_nxt = asm_active;
          asm_nxt   = 1'b1;
          exp_nxt   = hdr_seq + 2'd1;
          tag_nxt   = hdr_tag;
        end
        TY_M: begin
`ifdef MCTP_SEQ_CHECK_EN
          hdr_ok = seq_ok;
          if (seq_ok) exp_nxt = exp_seq + 2'd1;
          else        asm_nxt = 1'b0;
`else
          hdr_ok  = 1'b1;
          exp_nxt = exp_seq + 2'd1;
`endif
        end
        TY_L: begin
`ifdef MCTP_SEQ_CHECK_EN
          hdr_ok = seq_ok;
`else
          hdr_ok = 1'b1;
`endif
          asm_nxt = 1'b0;
        end
        TY_SG: begin
          hdr_ok    = 1'b1;
          abort_nxt = asm_active;
          asm_nxt   = 1'b0;
        end
      endcase
    end
  end

  // Beat 0 decides from the live header; later beats reuse the latched verdict
  logic drop_now, fwd, eom_type_now, wlast_bad;
  assign drop_now     = first_beat ? !hdr_ok : pkt_drop;
  assign fwd          = w_hs && !drop_now;
  assign eom_type_now = first_beat ? ((hdr_type == TY_L) || (hdr_type == TY_SG)) : pkt_eom;
  assign wlast_bad    = (I_WLAST != last_beat);

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (aw_hs) state_nxt = ST_DATA;
      ST_DATA: if (w_hs && last_beat) state_nxt = ST_RESP;
      ST_RESP: if (b_hs) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs; AWREADY waits one cycle after reset release
  always_comb begin
    O_AWREADY = (state == ST_IDLE) && rst_done;
    O_WREADY  = (state == ST_DATA) && (pkt_drop || !O_PLD_VALID || I_PLD_READY);
    O_BVALID  = (state == ST_RESP);
    O_BRESP   = (state == ST_RESP) ? bresp_q : 2'b00;
    O_BID     = aw_id;
  end

  // Burst bookkeeping: latched AW fields, beat count, per-packet verdicts and response
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rst_done  <= 1'b0;
      aw_id     <= '0;
      aw_len    <= '0;
      beat_cnt  <= '0;
      pkt_drop  <= 1'b0;
      pkt_eom   <= 1'b0;
      wlast_err <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      rst_done <= 1'b1;
      if (aw_hs) begin
        aw_id     <= I_AWID;
        aw_len    <= I_AWLEN;
        beat_cnt  <= '0;
        pkt_drop  <= 1'b0;
        pkt_eom   <= 1'b0;
        wlast_err <= 1'b0;
      end
      if (w_hs) begin
        beat_cnt  <= beat_cnt + 8'd1;
        wlast_err <= wlast_err | wlast_bad;
        if (first_beat) begin
          pkt_drop <= !hdr_ok;
          pkt_eom  <= eom_type_now;
        end
        if (last_beat)
          bresp_q <= (drop_now || wlast_err || wlast_bad) ? 2'b10 : 2'b00;
      end
    end
  end

  // MCTP assembly state and abort pulse, updated only on beat 0
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      asm_active <= 1'b0;
      exp_seq    <= 2'd0;
      cur_tag    <= 4'd0;
      O_ABORT    <= 1'b0;
    end else begin
      O_ABORT <= w_hs && first_beat && abort_nxt;
      if (w_hs && first_beat) begin
        asm_active <= asm_nxt;
        exp_seq    <= exp_nxt;
        cur_tag    <= tag_nxt;
      end
    end
  end

  // One-entry payload output register, held until I_PLD_READY
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      O_PLD_VALID <= 1'b0;
      O_PLD_DATA  <= '0;
      O_PLD_SOM   <= 1'b0;
      O_PLD_EOM   <= 1'b0;
      O_PLD_LAST  <= 1'b0;
      O_PLD_TAG   <= 4'd0;
      O_PLD_SEQ   <= 2'd0;
    end else if (fwd) begin
      O_PLD_VALID <= 1'b1;
      O_PLD_DATA  <= I_WDATA;
      O_PLD_SOM   <= first_beat && ((hdr_type == TY_S) || (hdr_type == TY_SG));
      O_PLD_EOM   <= last_beat && eom_type_now;
      O_PLD_LAST  <= last_beat;
      if (first_beat) begin
        O_PLD_TAG <= hdr_tag;
        O_PLD_SEQ <= hdr_seq;
      end
    end else if (I_PLD_READY) begin
      O_PLD_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mctp_axi_wr_rx.sv
// Scoreboard bench for mctp_axi_wr_rx: directed MCTP packet sequences, expectations queued at issue time,
// a negedge monitor pops and compares every payload and B handshake.
module tb_mctp_axi_wr_rx;

  logic         clk = 1'b0;
  logic         i_reset_n;
  logic [6:0]   I_AWID;
  logic [63:0]  I_AWADDR;
  logic [7:0]   I_AWLEN;
  logic [2:0]   I_AWSIZE;
  logic [1:0]   I_AWBURST;
  logic         I_AWVALID;
  logic         O_AWREADY;
  logic [255:0] I_WDATA;
  logic         I_WLAST;
  logic         I_WVALID;
  logic         O_WREADY;
  logic [6:0]   O_BID;
  logic [1:0]   O_BRESP;
  logic         O_BVALID;
  logic         I_BREADY;
  logic [255:0] O_PLD_DATA;
  logic         O_PLD_VALID;
  logic         I_PLD_READY;
  logic         O_PLD_SOM;
  logic         O_PLD_EOM;
  logic         O_PLD_LAST;
  logic [3:0]   O_PLD_TAG;
  logic [1:0]   O_PLD_SEQ;
  logic         O_ABORT;

  always #5 clk = ~clk;

  mctp_axi_wr_rx dut (
    .i_clk(clk), .i_reset_n(i_reset_n),
    .I_AWID(I_AWID), .I_AWADDR(I_AWADDR), .I_AWLEN(I_AWLEN), .I_AWSIZE(I_AWSIZE),
    .I_AWBURST(I_AWBURST), .I_AWVALID(I_AWVALID), .O_AWREADY(O_AWREADY),
    .I_WDATA(I_WDATA), .I_WLAST(I_WLAST), .I_WVALID(I_WVALID), .O_WREADY(O_WREADY),
    .O_BID(O_BID), .O_BRESP(O_BRESP), .O_BVALID(O_BVALID), .I_BREADY(I_BREADY),
    .O_PLD_DATA(O_PLD_DATA), .O_PLD_VALID(O_PLD_VALID), .I_PLD_READY(I_PLD_READY),
    .O_PLD_SOM(O_PLD_SOM), .O_PLD_EOM(O_PLD_EOM), .O_PLD_LAST(O_PLD_LAST),
    .O_PLD_TAG(O_PLD_TAG), .O_PLD_SEQ(O_PLD_SEQ), .O_ABORT(O_ABORT)
  );

`ifdef MCTP_SEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam logic [1:0] T_M = 2'b00, T_L = 2'b01, T_S = 2'b10, T_SG = 2'b11;

  typedef struct packed {
    logic [255:0] data;
    logic         som;
    logic         eom;
    logic         last;
    logic [3:0]   tag;
    logic [1:0]   seq;
  } beat_t;

  typedef struct packed {
    logic [6:0] id;
    logic [1:0] resp;
  } bexp_t;

  beat_t pq[$];
  bexp_t bq[$];
  int checks = 0;
  int errors = 0;
  int abort_cnt = 0;
  int pld_cnt = 0;
  int pkt_no = 0;
  bit tog_en = 1'b0;

  task automatic check(input string name, input logic [271:0] act, input logic [271:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk_hdr(input logic [1:0] typ, input logic [1:0] sq,
                                          input logic [3:0] tg, input bit good_fmt);
    logic [127:0] h;
    h          = '0;
    h[7:3]     = 5'b01110;
    h[31:8]    = 24'h12_3456;
    h[63:56]   = good_fmt ? 8'h7F : 8'h00;
    h[95:80]   = 16'hB41A;
    h[127:126] = typ;
    h[125:124] = sq;
    h[123:120] = tg;
    return h;
  endfunction

  function automatic logic [255:0] beat_data(input int pno, input int i, input logic [127:0] hdr);
    if (i == 0) return {8'(pno), 8'h00, {7{16'hC3A5}}, hdr};
    else        return {8'(pno), 8'(i), {15{16'h5A3C}}};
  endfunction

  task automatic chk_reset_outputs(input string name);
    check(name, 272'({O_AWREADY, O_WREADY, O_BVALID, O_BID, O_BRESP, O_PLD_VALID, O_PLD_SOM,
                       O_PLD_EOM, O_PLD_LAST, O_PLD_TAG, O_PLD_SEQ, O_ABORT}), 272'(0));
    check({name, "_data"}, 272'(O_PLD_DATA), 272'(0));
  endtask

  // Issue one burst; stop_after >= 0 abandons the burst after that beat (no B expected)
  task automatic send_pkt(input logic [1:0] typ, input logic [1:0] sq, input logic [3:0] tg,
                          input int len, input bit good_fmt, input bit exp_ok, input bit exp_fwd,
                          input int bad_last, input int stop_after);
    logic [127:0] hdr;
    logic [6:0]   id;
    beat_t        e;
    bexp_t        b;
    bit           hs;
    int           to;
    id  = 7'(pkt_no);
    hdr = mk_hdr(typ, sq, tg, good_fmt);
    for (int i = 0; i <= len; i++) begin
      if (exp_fwd && (stop_after < 0 || i <= stop_after)) begin
        e.data = beat_data(pkt_no, i, hdr);
        e.som  = (i == 0) && (typ == T_S || typ == T_SG);
        e.eom  = (i == len) && (typ == T_L || typ == T_SG);
        e.last = (i == len);
        e.tag  = tg;
        e.seq  = sq;
        pq.push_back(e);
      end
    end
    if (stop_after < 0) begin
      b.id   = id;
      b.resp = exp_ok ? 2'b00 : 2'b10;
      bq.push_back(b);
    end
    I_AWID    = id;
    I_AWLEN   = 8'(len);
    I_AWADDR  = 64'h1000 + 64'(pkt_no);
    I_AWVALID = 1'b1;
    hs = 1'b0;
    to = 0;
    while (!hs && to < 200) begin
      @(negedge clk);
      hs = O_AWREADY;
      @(posedge clk); #1;
      to++;
    end
    I_AWVALID = 1'b0;
    if (!hs) begin
      checks++; errors++;
      $display("FAIL aw_timeout: got no AWREADY within %0d cycles, required handshake", to);
      pkt_no++;
      return;
    end
    for (int i = 0; i <= len; i++) begin
      I_WDATA  = beat_data(pkt_no, i, hdr);
      I_WLAST  = (i == len) != (i == bad_last);
      I_WVALID = 1'b1;
      hs = 1'b0;
      to = 0;
      while (!hs && to < 200) begin
        @(negedge clk);
        if (to == 0 && i > 0 && exp_fwd) check("pld_latency", 272'(O_PLD_VALID), 272'(1));
        hs = O_WREADY;
        @(posedge clk); #1;
        to++;
      end
      if (!hs) begin
        checks++; errors++;
        $display("FAIL w_timeout: got no WREADY on beat %0d, required handshake", i);
        I_WVALID = 1'b0;
        pkt_no++;
        return;
      end
      if (stop_after == i) begin
        I_WVALID = 1'b0;
        pkt_no++;
        return;
      end
    end
    I_WVALID = 1'b0;
    @(negedge clk);
    check("bvalid_timing", 272'(O_BVALID), 272'(1));
    if (exp_fwd) check("pld_latency", 272'(O_PLD_VALID), 272'(1));
    hs = O_BVALID;
    to = 0;
    while (!hs && to < 200) begin
      @(posedge clk); #1;
      @(negedge clk);
      hs = O_BVALID;
      to++;
    end
    if (!hs) begin
      checks++; errors++;
      $display("FAIL b_timeout: got no BVALID, required response");
    end
    @(posedge clk); #1;
    pkt_no++;
  endtask

  // Monitor: compare every payload and B handshake against the scoreboard
  initial begin
    beat_t em;
    bexp_t eb;
    forever begin
      @(negedge clk);
      if (O_ABORT) abort_cnt++;
      if (O_PLD_VALID && I_PLD_READY) begin
        pld_cnt++;
        if (pq.size() == 0) begin
          checks++; errors++;
          $display("FAIL pld_unexpected: got beat %0h, required none", O_PLD_DATA[255:240]);
        end else begin
          em = pq.pop_front();
          check("pld_beat", 272'({O_PLD_DATA, O_PLD_SOM, O_PLD_EOM, O_PLD_LAST, O_PLD_TAG, O_PLD_SEQ}),
                272'(em));
        end
      end
      if (O_BVALID && I_BREADY) begin
        if (bq.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected: got id %0d resp %0d, required none", O_BID, O_BRESP);
        end else begin
          eb = bq.pop_front();
          check("bresp", 272'({O_BID, O_BRESP}), 272'(eb));
        end
      end
    end
  end

  // Payload-ready driver: constant 1 or toggling every cycle
  initial begin
    I_PLD_READY = 1'b1;
    forever begin
      @(posedge clk); #1;
      I_PLD_READY = tog_en ? ~I_PLD_READY : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    i_reset_n = 1'b0;
    I_AWID = '0; I_AWADDR = '0; I_AWLEN = '0; I_AWSIZE = 3'd5; I_AWBURST = 2'b01;
    I_AWVALID = 1'b0; I_WDATA = '0; I_WLAST = 1'b0; I_WVALID = 1'b0; I_BREADY = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset_outs");
    @(posedge clk); #1;
    i_reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("awready_after_reset", 272'(O_AWREADY), 272'(1));
    @(posedge clk); #1;

    // S0 M1 M2 L3 twice, tag 6
    base = pld_cnt;
    repeat (2) begin
      send_pkt(T_S, 2'd0, 4'd6, 3, 1, 1, 1, -1, -1);
      send_pkt(T_M, 2'd1, 4'd6, 3, 1, 1, 1, -1, -1);
      send_pkt(T_M, 2'd2, 4'd6, 3, 1, 1, 1, -1, -1);
      send_pkt(T_L, 2'd3, 4'd6, 3, 1, 1, 1, -1, -1);
    end
    settle();
    check("seq_beats", 272'(pld_cnt - base), 272'(32));
    check("seq_abort", 272'(abort_cnt), 272'(0));

    // Sequence gap: S0 then M2, then L3
    base = pld_cnt;
    send_pkt(T_S, 2'd0, 4'd6, 3, 1, 1, 1, -1, -1);
    send_pkt(T_M, 2'd2, 4'd6, 3, 1, !CHK, !CHK, -1, -1);
    send_pkt(T_L, 2'd3, 4'd6, 3, 1, !CHK, !CHK, -1, -1);
    settle();
    check("gap_beats", 272'(pld_cnt - base), 272'(CHK ? 4 : 12));
    check("gap_abort", 272'(abort_cnt), 272'(0));

    // Tag mismatch, then SG closes any open message
    base = pld_cnt;
    send_pkt(T_S, 2'd0, 4'd6, 3, 1, 1, 1, -1, -1);
    send_pkt(T_M, 2'd1, 4'd5, 3, 1, !CHK, !CHK, -1, -1);
    settle();
    check("tag_beats", 272'(pld_cnt - base), 272'(CHK ? 4 : 8));
    send_pkt(T_SG, 2'd0, 4'd1, 1, 1, 1, 1, -1, -1);
    settle();
    check("tag_abort", 272'(abort_cnt), 272'(CHK ? 0 : 1));

    // S then S again: one abort
    base = pld_cnt;
    send_pkt(T_S, 2'd0, 4'd6, 3, 1, 1, 1, -1, -1);
    send_pkt(T_S, 2'd0, 4'd6, 3, 1, 1, 1, -1, -1);
    settle();
    check("ss_beats", 272'(pld_cnt - base), 272'(8));
    check("ss_abort", 272'(abort_cnt), 272'(CHK ? 1 : 2));

    // SG with toggling payload ready (aborts the open S)
    base = pld_cnt;
    tog_en = 1'b1;
    send_pkt(T_SG, 2'd0, 4'd3, 3, 1, 1, 1, -1, -1);
    tog_en = 1'b0;
    settle();
    check("tog_beats", 272'(pld_cnt - base), 272'(4));
    check("tog_abort", 272'(abort_cnt), 272'(CHK ? 2 : 3));

    // Bad format byte
    base = pld_cnt;
    send_pkt(T_S, 2'd0, 4'd6, 3, 0, 0, 0, -1, -1);
    settle();
    check("fmt_beats", 272'(pld_cnt - base), 272'(0));

    // WLAST early and WLAST missing: SLVERR but forwarded; then single-beat SG
    base = pld_cnt;
    send_pkt(T_SG, 2'd1, 4'd7, 3, 1, 0, 1, 1, -1);
    send_pkt(T_SG, 2'd2, 4'd8, 1, 1, 0, 1, 1, -1);
    send_pkt(T_SG, 2'd3, 4'd9, 0, 1, 1, 1, -1, -1);
    settle();
    check("wlast_beats", 272'(pld_cnt - base), 272'(7));

    // Reset after beat 2 of an S packet, then SG
    send_pkt(T_S, 2'd0, 4'd2, 3, 1, 1, 1, -1, 2);
    @(posedge clk); #1;
    i_reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("midreset_outs");
    check("midreset_drained", 272'(pq.size()), 272'(0));
    @(posedge clk); #1;
    i_reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("awready_after_midreset", 272'(O_AWREADY), 272'(1));
    @(posedge clk); #1;
    base = pld_cnt;
    send_pkt(T_SG, 2'd0, 4'd4, 1, 1, 1, 1, -1, -1);
    settle();
    check("post_reset_beats", 272'(pld_cnt - base), 272'(2));

    check("pld_queue_empty", 272'(pq.size()), 272'(0));
    check("b_queue_empty", 272'(bq.size()), 272'(0));
    check("abort_total", 272'(abort_cnt), 272'(CHK ? 2 : 3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
